leglite_seq: RTL and testbench

Multicycle sequencer for the LEGLite datapath: steps each instruction through fetch, decode, execute, memory and write-back phases, and emits the phase strobes that gate the PC, instruction register, register file and the single shared instruction/data memory port. It arbitrates that port between instruction fetch and LDUR/STUR data access using a req/ack handshake. It sits between the top level and the datapath; the opcode decoder keeps producing the static mux/ALU controls, and this block decides when they take effect.

---
 rtl/leglite_pkg.sv | 22 ++
 rtl/leglite_seq_if.sv | 41 ++++
 rtl/leglite_seq_op_class.sv | 21 ++
 rtl/leglite_seq.sv | 135 +++++++++++++
 tb/tb_leglite_seq.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leglite_pkg.sv
// Shared LEGLite definitions: opcode encodings, sequencer states and opcode classes.
package leglite_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_B    = 4'd4;
    localparam logic [3:0] OP_LDUR = 4'd5;
    localparam logic [3:0] OP_STUR = 4'd6;
    localparam logic [3:0] OP_CBZ  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_ANDI = 4'd9;
    localparam logic [3:0] OP_SUBI = 4'd10;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB
    } seq_state_t;

    typedef enum logic [2:0] {
        ALU, BR, CBZ, LD, ST, ILLEGAL
    } op_class_t;

endpackage

// File: rtl/leglite_seq_if.sv
// Sequencer <-> datapath control bundle. The step input exists only when
// LEGLITE_SEQ_STEP_EN is defined.
interface leglite_seq_if #(parameter int CNT_W = 16);

`ifdef LEGLITE_SEQ_STEP_EN
    logic             step;
`endif
    logic             run;
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             ir_load;
    logic             pc_write;
    logic             pc_sel_br;
    logic             rf_we;
    logic             rf_src_mem;
    logic             busy;
    logic [CNT_W-1:0] instr_count;

    modport master (
`ifdef LEGLITE_SEQ_STEP_EN
        input  step,
`endif
        input  run, opcode, zero, mem_ack,
        output mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_sel_br,
        output rf_we, rf_src_mem, busy, instr_count
    );

    modport slave (
`ifdef LEGLITE_SEQ_STEP_EN
        output step,
`endif
        output run, opcode, zero, mem_ack,
        input  mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_sel_br,
        input  rf_we, rf_src_mem, busy, instr_count
    );

endinterface

// File: rtl/leglite_seq_op_class.sv
// Combinational opcode classifier; unlisted opcodes fall into ILLEGAL.
module leglite_op_class
    import leglite_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        o_class = ILLEGAL;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_ADDI, OP_ANDI, OP_SUBI: o_class = ALU;
            OP_B:                                      o_class = BR;
            OP_LDUR:                                   o_class = LD;
            OP_STUR:                                   o_class = ST;
            OP_CBZ:                                    o_class = CBZ;
            default:                                   o_class = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/leglite_seq.sv
// LEGLite multicycle sequencer: phase strobes and shared memory port arbitration.
// Optional single-step start in IDLE when LEGLITE_SEQ_STEP_EN is defined.
module leglite_seq
    import leglite_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clock,
    input  logic          reset,
    leglite_seq_if.master bus
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    op_class_t        w_class;
    logic [CNT_W-1:0] r_count;
    logic             w_start;
    logic             w_retire;
    logic             w_mem_req;
    logic             w_mem_we;
    logic             w_mem_addr_sel;
    logic             w_ir_load;
    logic             w_pc_write;
    logic             w_pc_sel_br;
    logic             w_rf_we;
    logic             w_rf_src_mem;

    leglite_op_class u_op_class (
        .i_opcode (bus.opcode),
        .o_class  (w_class)
    );

`ifdef LEGLITE_SEQ_STEP_EN
    assign w_start = bus.run | bus.step;
`else
    assign w_start = bus.run;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Strobes are pure functions of state and live inputs so they can gate the datapath in-cycle.
    always_comb begin
        w_next         = r_state;
        w_retire       = 1'b0;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_load      = 1'b0;
        w_pc_write     = 1'b0;
        w_pc_sel_br    = 1'b0;
        w_rf_we        = 1'b0;
        w_rf_src_mem   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_next = FETCH;
            end
            FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_ir_load = 1'b1;
                    w_next    = DECODE;
                end
            end
            DECODE: w_next = EXEC;
            EXEC: begin
                case (w_class)
                    ALU:    w_next = WB;
                    LD, ST: w_next = MEM;
                    BR: begin
                        w_pc_write  = 1'b1;
                        w_pc_sel_br = 1'b1;
                        w_retire    = 1'b1;
                    end
                    CBZ: begin
                        w_pc_write  = 1'b1;
                        w_pc_sel_br = bus.zero;
                        w_retire    = 1'b1;
                    end
                    default: begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                    end
                endcase
            end
            MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (w_class == ST);
                if (bus.mem_ack) begin
                    if (w_class == LD) begin
                        w_next = WB;
                    end else begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                    end
                end
            end
            WB: begin
                w_rf_we      = 1'b1;
                w_rf_src_mem = (w_class == LD);
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
            end
            default: w_next = IDLE;
        endcase
        // run is only honoured at instruction boundaries
        if (w_retire) w_next = bus.run ? FETCH : IDLE;
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_addr_sel = w_mem_addr_sel;
    assign bus.ir_load      = w_ir_load;
    assign bus.pc_write     = w_pc_write;
    assign bus.pc_sel_br    = w_pc_sel_br;
    assign bus.rf_we        = w_rf_we;
    assign bus.rf_src_mem   = w_rf_src_mem;
    assign bus.busy         = (r_state != IDLE);
    assign bus.instr_count  = r_count;

endmodule

// File: tb/tb_leglite_seq.sv
// Directed bench for leglite_seq; exercises step mode when LEGLITE_SEQ_STEP_EN is defined.
module tb_leglite_seq;

    localparam int CNT_W = 16;

    // Output vector bit order: mem_req, mem_we, mem_addr_sel, ir_load, pc_write,
    // pc_sel_br, rf_we, rf_src_mem, busy
    localparam logic [8:0] E_IDLE    = 9'b000000000;
    localparam logic [8:0] E_FWAIT   = 9'b100000001;
    localparam logic [8:0] E_FACK    = 9'b100100001;
    localparam logic [8:0] E_NONE    = 9'b000000001;
    localparam logic [8:0] E_BR      = 9'b000011001;
    localparam logic [8:0] E_PCSEQ   = 9'b000010001;
    localparam logic [8:0] E_MLD     = 9'b101000001;
    localparam logic [8:0] E_MST     = 9'b111000001;
    localparam logic [8:0] E_MST_ACK = 9'b111010001;
    localparam logic [8:0] E_WB_ALU  = 9'b000010101;
    localparam logic [8:0] E_WB_LD   = 9'b000010111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    leglite_seq_if #(.CNT_W(CNT_W)) bus ();

    leglite_seq #(.CNT_W(CNT_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_load, bus.pc_write,
                bus.pc_sel_br, bus.rf_we, bus.rf_src_mem, bus.busy};
    endfunction

    // Row = {run, mem_ack, zero, opcode, expected outputs}
    function automatic logic [15:0] row(input logic r, input logic a, input logic z,
                                        input logic [3:0] op, input logic [8:0] e);
        return {r, a, z, op, e};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.mem_ack = 1'b0; bus.zero = 1'b0; bus.opcode = 4'd0;
`ifdef LEGLITE_SEQ_STEP_EN
        bus.step = 1'b0;
`endif
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs() !== E_IDLE) begin
            n_fail++; $display("FAIL reset_outs: got %b expected %b", outs(), E_IDLE);
        end
        n_checks++;
        if (bus.instr_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.instr_count);
        end
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_idle_hold();
        bus.run = 1'b0; bus.mem_ack = 1'b1; bus.opcode = 4'd5;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (outs() !== E_IDLE) begin
                n_fail++; $display("FAIL idle_hold cyc%0d: got %b expected %b", i, outs(), E_IDLE);
            end
            next_cycle();
        end
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.instr_count !== 16'd0) begin
            n_fail++; $display("FAIL idle_hold_count: got %0d expected 0", bus.instr_count);
        end
    endtask

    task automatic test_alu();
        logic [15:0] v [6];
        v = '{row(1,1,0,4'd0,E_IDLE), row(1,1,0,4'd0,E_FACK), row(1,1,0,4'd0,E_NONE),
              row(1,1,0,4'd0,E_NONE), row(0,1,0,4'd0,E_WB_ALU), row(0,0,0,4'd0,E_IDLE)};
        for (int i = 0; i < 6; i++) begin
            {bus.run, bus.mem_ack, bus.zero, bus.opcode} = v[i][15:9];
            #1;
            n_checks++;
            if (outs() !== v[i][8:0]) begin
                n_fail++; $display("FAIL alu cyc%0d: got %b expected %b", i, outs(), v[i][8:0]);
            end
            next_cycle();
        end
        n_checks++;
        if (bus.instr_count !== 16'd1) begin
            n_fail++; $display("FAIL alu_count: got %0d expected 1", bus.instr_count);
        end
    endtask

    task automatic test_ld_wait();
        logic [15:0] v [10];
        v = '{row(1,0,0,4'd5,E_IDLE), row(1,1,0,4'd5,E_FACK), row(1,0,0,4'd5,E_NONE),
              row(1,0,0,4'd5,E_NONE), row(1,0,0,4'd5,E_MLD), row(1,0,0,4'd5,E_MLD),
              row(1,0,0,4'd5,E_MLD), row(1,1,0,4'd5,E_MLD), row(0,0,0,4'd5,E_WB_LD),
              row(0,0,0,4'd5,E_IDLE)};
        for (int i = 0; i < 10; i++) begin
            {bus.run, bus.mem_ack, bus.zero, bus.opcode} = v[i][15:9];
            #1;
            n_checks++;
            if (outs() !== v[i][8:0]) begin
                n_fail++; $display("FAIL ld_wait cyc%0d: got %b expected %b", i, outs(), v[i][8:0]);
            end
            next_cycle();
        end
        n_checks++;
        if (bus.instr_count !== 16'd2) begin
            n_fail++; $display("FAIL ld_wait_count: got %0d expected 2", bus.instr_count);
        end
    endtask

    task automatic test_cbz();
        logic [15:0] v [10];
        v = '{row(1,0,0,4'd7,E_IDLE), row(1,1,0,4'd7,E_FACK), row(1,1,1,4'd7,E_NONE),
              row(0,1,1,4'd7,E_BR), row(1,0,0,4'd7,E_IDLE), row(1,0,0,4'd7,E_FWAIT),
              row(1,1,0,4'd7,E_FACK), row(1,1,0,4'd7,E_NONE), row(0,1,0,4'd7,E_PCSEQ),
              row(0,0,0,4'd7,E_IDLE)};
        for (int i = 0; i < 10; i++) begin
            {bus.run, bus.mem_ack, bus.zero, bus.opcode} = v[i][15:9];
            #1;
            n_checks++;
            if (outs() !== v[i][8:0]) begin
                n_fail++; $display("FAIL cbz cyc%0d: got %b expected %b", i, outs(), v[i][8:0]);
            end
            next_cycle();
        end
        n_checks++;
        if (bus.instr_count !== 16'd4) begin
            n_fail++; $display("FAIL cbz_count: got %0d expected 4", bus.instr_count);
        end
    endtask

    task automatic test_st_run_drop();
        logic [15:0] v [7];
        v = '{row(1,0,0,4'd6,E_IDLE), row(1,1,0,4'd6,E_FACK), row(0,0,0,4'd6,E_NONE),
              row(0,0,0,4'd6,E_NONE), row(0,0,0,4'd6,E_MST), row(0,1,0,4'd6,E_MST_ACK),
              row(0,0,0,4'd6,E_IDLE)};
        for (int i = 0; i < 7; i++) begin
            {bus.run, bus.mem_ack, bus.zero, bus.opcode} = v[i][15:9];
            #1;
            n_checks++;
            if (outs() !== v[i][8:0]) begin
                n_fail++; $display("FAIL st_run_drop cyc%0d: got %b expected %b", i, outs(), v[i][8:0]);
            end
            next_cycle();
        end
        n_checks++;
        if (bus.instr_count !== 16'd5) begin
            n_fail++; $display("FAIL st_count: got %0d expected 5", bus.instr_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v [8];
        v = '{row(1,0,0,4'd4,E_IDLE), row(1,1,0,4'd4,E_FACK), row(1,0,0,4'd4,E_NONE),
              row(1,0,0,4'd4,E_BR), row(1,1,0,4'd4,E_FACK), row(1,0,0,4'd4,E_NONE),
              row(0,0,0,4'd4,E_BR), row(0,0,0,4'd4,E_IDLE)};
        for (int i = 0; i < 8; i++) begin
            {bus.run, bus.mem_ack, bus.zero, bus.opcode} = v[i][15:9];
            #1;
            n_checks++;
            if (outs() !== v[i][8:0]) begin
                n_fail++; $display("FAIL back_to_back cyc%0d: got %b expected %b", i, outs(), v[i][8:0]);
            end
            next_cycle();
        end
        n_checks++;
        if (bus.instr_count !== 16'd7) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 7", bus.instr_count);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] v [5];
        v = '{row(1,0,0,4'd15,E_IDLE), row(1,1,0,4'd15,E_FACK), row(1,1,0,4'd15,E_NONE),
              row(0,1,0,4'd15,E_PCSEQ), row(0,1,0,4'd15,E_IDLE)};
        for (int i = 0; i < 5; i++) begin
            {bus.run, bus.mem_ack, bus.zero, bus.opcode} = v[i][15:9];
            #1;
            n_checks++;
            if (outs() !== v[i][8:0]) begin
                n_fail++; $display("FAIL illegal cyc%0d: got %b expected %b", i, outs(), v[i][8:0]);
            end
            next_cycle();
        end
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.instr_count !== 16'd8) begin
            n_fail++; $display("FAIL illegal_count: got %0d expected 8", bus.instr_count);
        end
    endtask

    task automatic test_reset_mem_wait();
        logic [15:0] v [5];
        v = '{row(1,0,0,4'd5,E_IDLE), row(1,1,0,4'd5,E_FACK), row(1,0,0,4'd5,E_NONE),
              row(1,0,0,4'd5,E_NONE), row(1,0,0,4'd5,E_MLD)};
        for (int i = 0; i < 5; i++) begin
            {bus.run, bus.mem_ack, bus.zero, bus.opcode} = v[i][15:9];
            #1;
            n_checks++;
            if (outs() !== v[i][8:0]) begin
                n_fail++; $display("FAIL rst_mem cyc%0d: got %b expected %b", i, outs(), v[i][8:0]);
            end
            next_cycle();
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs() !== E_IDLE) begin
            n_fail++; $display("FAIL rst_mem_outs: got %b expected %b", outs(), E_IDLE);
        end
        n_checks++;
        if (bus.instr_count !== 16'd0) begin
            n_fail++; $display("FAIL rst_mem_count: got %0d expected 0", bus.instr_count);
        end
        bus.run = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        #1;
        n_checks++;
        if (outs() !== E_IDLE) begin
            n_fail++; $display("FAIL rst_mem_after: got %b expected %b", outs(), E_IDLE);
        end
    endtask

`ifdef LEGLITE_SEQ_STEP_EN
    task automatic test_step();
        logic [15:0] v [6];
        v = '{row(0,0,0,4'd4,E_IDLE), row(0,1,0,4'd4,E_FACK), row(0,0,0,4'd4,E_NONE),
              row(0,0,0,4'd4,E_BR), row(0,0,0,4'd4,E_IDLE), row(0,0,0,4'd4,E_IDLE)};
        for (int i = 0; i < 6; i++) begin
            {bus.run, bus.mem_ack, bus.zero, bus.opcode} = v[i][15:9];
            // pulse in IDLE starts; the later one in EXEC must be ignored
            bus.step = (i == 0) || (i == 3);
            #1;
            n_checks++;
            if (outs() !== v[i][8:0]) begin
                n_fail++; $display("FAIL step cyc%0d: got %b expected %b", i, outs(), v[i][8:0]);
            end
            next_cycle();
        end
        bus.step = 1'b0;
        n_checks++;
        if (bus.instr_count !== 16'd1) begin
            n_fail++; $display("FAIL step_count: got %0d expected 1", bus.instr_count);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_hold();
        test_alu();
        test_ld_wait();
        test_cbz();
        test_st_run_drop();
        test_back_to_back();
        test_illegal();
        test_reset_mem_wait();
`ifdef LEGLITE_SEQ_STEP_EN
        test_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
